// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants, instruction layout and decode helpers for
//                the ALU issue/writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Datapath geometry (fixed by the downstream 16-bit ALU)
    localparam int ALU_DW   = 16;
    localparam int ALU_AW   = 3;
    localparam int ALU_NREG = 8;

    // Opcodes; 0..10 go to the ALU, 11 is load-immediate, 12..15 illegal
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_SRA = 4'd4;
    localparam logic [3:0] OP_ROL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_NOR = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_LDI = 4'd11;

    // Instruction field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int SH_MSB  = 3;
    localparam int SH_LSB  = 0;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    // Condition code bit order {N,Z,C,V}
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    typedef struct packed {
        logic [3:0]        op;
        logic [ALU_AW-1:0] rd;
        logic [ALU_AW-1:0] ra;
        logic [ALU_AW-1:0] rb;
        logic [3:0]        shamt;
        logic [8:0]        imm9;
    } instr_t;

    // Split an instruction word into its (overlapping) fields
    function automatic instr_t decode(input logic [15:0] word);
        instr_t d;
        d.op    = word[OP_MSB:OP_LSB];
        d.rd    = word[RD_MSB:RD_LSB];
        d.ra    = word[RA_MSB:RA_LSB];
        d.rb    = word[RB_MSB:RB_LSB];
        d.shamt = word[SH_MSB:SH_LSB];
        d.imm9  = word[IMM_MSB:IMM_LSB];
        return d;
    endfunction

    // Sign-extend the 9-bit immediate to the datapath width
    function automatic logic [ALU_DW-1:0] sext_imm9(input logic [8:0] imm);
        return {{(ALU_DW-9){imm[8]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : 8 x DW register file, two combinational read ports, one
//                write port and one combinational debug read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW   = ALU_DW,
    parameter int AW   = ALU_AW,
    parameter int NREG = ALU_NREG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    // Storage: cleared on reset, one write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see committed contents only; a same-cycle write appears after the edge
    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Issue/writeback stage in front of the 16-bit ALU. Decodes one
//                instruction per cycle, reads/forwards operands, registers the
//                ALU inputs and commits the ALU result and condition codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int AW = ALU_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    output logic [DW-1:0] alu_valA,
    output logic [DW-1:0] alu_valB,
    output logic [3:0]    alu_aluop,
    output logic [3:0]    alu_shift,
    output logic          alu_sub,
    output logic          alu_lr,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_cc,
    output logic [3:0]    cc_q,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          err,
    input  logic          err_clr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    instr_t        w_ins;
    logic          w_accept;
    logic          w_legal;
    logic          w_is_ldi;
    logic          w_issue;
    logic [DW-1:0] w_rf_a;
    logic [DW-1:0] w_rf_b;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic [DW-1:0] w_wb_data;

    logic          r_ex_valid;
    logic [AW-1:0] r_ex_rd;
    logic          r_ex_ldi;
    logic [DW-1:0] r_ex_imm;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [3:0]    r_alu_op;
    logic [3:0]    r_alu_sh;
    logic [3:0]    r_cc;
    logic          r_err;

    assign w_ins    = decode(in_instr);
    assign w_accept = in_valid & in_ready;
    assign w_legal  = (w_ins.op <= OP_LDI);
    assign w_is_ldi = (w_ins.op == OP_LDI);
    assign w_issue  = w_accept & w_legal;

    // The instruction in ex commits this cycle; LDI bypasses the ALU
    assign w_wb_data = r_ex_ldi ? r_ex_imm : alu_result;

    // Operand bypass from the committing instruction, per operand
    assign w_op_a = (r_ex_valid && (r_ex_rd == w_ins.ra)) ? w_wb_data : w_rf_a;
    assign w_op_b = (r_ex_valid && (r_ex_rd == w_ins.rb)) ? w_wb_data : w_rf_b;

    alu_regfile #(
        .DW   (DW),
        .AW   (AW),
        .NREG (ALU_NREG)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (r_ex_valid),
        .i_waddr    (r_ex_rd),
        .i_wdata    (w_wb_data),
        .i_raddr_a  (w_ins.ra),
        .o_rdata_a  (w_rf_a),
        .i_raddr_b  (w_ins.rb),
        .o_rdata_b  (w_rf_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Execute slot: tracks the instruction whose result commits next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_ex_ldi   <= 1'b0;
            r_ex_imm   <= '0;
        end else begin
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_rd  <= w_ins.rd;
                r_ex_ldi <= w_is_ldi;
                r_ex_imm <= sext_imm9(w_ins.imm9);
            end
        end
    end

    // ALU input registers: loaded on a legal accept, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_alu_sh <= '0;
        end else if (w_issue) begin
            if (w_is_ldi) begin
                r_alu_a  <= '0;
                r_alu_b  <= '0;
                r_alu_op <= OP_ADD;
                r_alu_sh <= '0;
            end else begin
                r_alu_a  <= w_op_a;
                r_alu_b  <= w_op_b;
                r_alu_op <= w_ins.op;
                r_alu_sh <= w_ins.shamt;
            end
        end
    end

    // Status register: only ALU-class commits update the condition codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= '0;
        end else if (r_ex_valid && !r_ex_ldi) begin
            r_cc <= alu_cc;
        end
    end

    // Sticky illegal-opcode flag; while set the stage refuses input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err <= 1'b1;
        end else if (err_clr && r_err) begin
            r_err <= 1'b0;
        end
    end

    assign in_ready  = ~r_err;
    assign err       = r_err;
    assign alu_valA  = r_alu_a;
    assign alu_valB  = r_alu_b;
    assign alu_aluop = r_alu_op;
    assign alu_shift = r_alu_sh;
    assign alu_sub   = (r_alu_op == OP_SUB);
    assign alu_lr    = (r_alu_op == OP_SHL) || (r_alu_op == OP_ROL);
    assign cc_q      = r_cc;
    assign wb_valid  = r_ex_valid;
    assign wb_addr   = r_ex_rd;
    assign wb_data   = w_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Directed self-checking bench for alu_issue with a small
//                behavioural ALU closing the result/condition-code loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] alu_valA;
    logic [15:0] alu_valB;
    logic [3:0]  alu_aluop;
    logic [3:0]  alu_shift;
    logic        alu_sub;
    logic        alu_lr;
    logic [15:0] alu_result;
    logic [3:0]  alu_cc;
    logic [3:0]  cc_q;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;
    logic        err_clr;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_valA   (alu_valA),
        .alu_valB   (alu_valB),
        .alu_aluop  (alu_aluop),
        .alu_shift  (alu_shift),
        .alu_sub    (alu_sub),
        .alu_lr     (alu_lr),
        .alu_result (alu_result),
        .alu_cc     (alu_cc),
        .cc_q       (cc_q),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .err        (err),
        .err_clr    (err_clr),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add, subtract, shift-left, xor for anything else
    logic [16:0] m_sum;
    logic        m_c;
    logic        m_v;
    always_comb begin
        m_sum = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_aluop)
            4'd0: begin
                m_sum = {1'b0, alu_valA} + {1'b0, alu_valB};
                m_c   = m_sum[16];
                m_v   = (alu_valA[15] == alu_valB[15]) && (m_sum[15] != alu_valA[15]);
            end
            4'd1: begin
                m_sum = {1'b0, alu_valA} - {1'b0, alu_valB};
                m_c   = m_sum[16];
                m_v   = (alu_valA[15] != alu_valB[15]) && (m_sum[15] != alu_valA[15]);
            end
            4'd2:    m_sum = {1'b0, alu_valA << alu_shift};
            default: m_sum = {1'b0, alu_valA ^ alu_valB};
        endcase
        alu_result = m_sum[15:0];
        alu_cc     = {m_sum[15], (m_sum[15:0] == 16'h0000), m_c, m_v};
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    logic [15:0] tp_val [8];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        err_clr  = 1'b0;
        dbg_addr = 3'd0;

        // ---------------- reset state ----------------
        #12;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_err",      {15'd0, err},      16'd0);
        check("rst_cc",       {12'd0, cc_q},     16'd0);
        check("rst_valA",     alu_valA,          16'd0);
        check("rst_aluop",    {12'd0, alu_aluop}, 16'd0);
        check("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        rd_check("rst_r3", 3'd3, 16'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // ---------------- dependent chain ----------------
        in_valid = 1'b1;
        in_instr = 16'hB205;                 // LDI r1,#5
        step();
        check("ldi1_wb_valid", {15'd0, wb_valid}, 16'd1);
        check("ldi1_wb_addr",  {13'd0, wb_addr},  16'd1);
        check("ldi1_wb_data",  wb_data,           16'h0005);
        check("ldi1_aluop",    {12'd0, alu_aluop}, 16'd0);
        rd_check("ldi1_dbg_old", 3'd1, 16'h0000);
        in_instr = 16'hB5FD;                 // LDI r2,#-3
        step();
        check("ldi2_wb_data", wb_data, 16'hFFFD);
        rd_check("r1_commit", 3'd1, 16'h0005);
        in_instr = 16'h0650;                 // ADD r3,r1,r2
        step();
        check("add_valA",    alu_valA, 16'h0005);
        check("add_valB",    alu_valB, 16'hFFFD);
        check("add_sub",     {15'd0, alu_sub}, 16'd0);
        check("add_wb_data", wb_data,  16'h0002);
        in_instr = 16'hBA00;                 // LDI r5,#0
        step();
        check("add_cc",   {12'd0, cc_q}, 16'h0002);
        rd_check("r3_commit", 3'd3, 16'h0002);
        in_valid = 1'b0;
        step();
        check("ldi_cc_keep",  {12'd0, cc_q},     16'h0002);
        check("idle_wb_valid", {15'd0, wb_valid}, 16'd0);
        rd_check("r5_commit", 3'd5, 16'h0000);

        // ---------------- shift ----------------
        in_valid = 1'b1;
        in_instr = 16'h2843;                 // SHL r4,r1,#3
        step();
        in_valid = 1'b0;
        check("shl_lr",    {15'd0, alu_lr},   16'd1);
        check("shl_shift", {12'd0, alu_shift}, 16'd3);
        check("shl_valA",  alu_valA,          16'h0005);
        step();
        rd_check("r4_commit", 3'd4, 16'h0028);
        check("shl_cc", {12'd0, cc_q}, 16'h0000);

        // ---------------- illegal opcode ----------------
        in_valid = 1'b1;
        in_instr = 16'hC000;
        step();
        check("ill_err",      {15'd0, err},      16'd1);
        check("ill_ready",    {15'd0, in_ready}, 16'd0);
        check("ill_wb_valid", {15'd0, wb_valid}, 16'd0);
        in_instr = 16'hBC07;                 // LDI r6,#7 offered while blocked
        step();
        check("blk_wb_valid", {15'd0, wb_valid}, 16'd0);
        step();
        in_valid = 1'b0;
        rd_check("blk_r6", 3'd6, 16'h0000);
        rd_check("blk_r1", 3'd1, 16'h0005);
        check("blk_err", {15'd0, err}, 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err",   {15'd0, err},      16'd0);
        check("clr_ready", {15'd0, in_ready}, 16'd1);

        // ---------------- reset mid-flight ----------------
        in_valid = 1'b1;
        in_instr = 16'h0E48;                 // ADD r7,r1,r1
        step();
        in_valid = 1'b0;
        check("mf_valA",    alu_valA, 16'h0005);
        check("mf_wb_addr", {13'd0, wb_addr}, 16'd7);
        #2 rst_n = 1'b0;
        #1;
        check("mf_valA_rst", alu_valA,          16'h0000);
        check("mf_aluop",    {12'd0, alu_aluop}, 16'd0);
        check("mf_cc",       {12'd0, cc_q},     16'd0);
        check("mf_wb_valid", {15'd0, wb_valid}, 16'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            rd_check($sformatf("mf_r%0d", i), 3'(i), 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- throughput ----------------
        for (int i = 0; i < 8; i++) begin
            tp_val[i] = (i % 2 == 1) ? (16'hFF00 | 16'(i)) : 16'(i + 10);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = {4'hB, 3'(i), tp_val[i][8:0]};
            step();
            check($sformatf("tp_wb_valid%0d", i), {15'd0, wb_valid}, 16'd1);
            check($sformatf("tp_wb_data%0d", i),  wb_data,           tp_val[i]);
        end
        in_valid = 1'b0;
        step();
        check("tp_done", {15'd0, wb_valid}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            rd_check($sformatf("tp_r%0d", i), 3'(i), tp_val[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
